// File: rtl/ir_fetch_pkg.sv
// Fetch-sequencer types and default sizes.
// State encoding shared by ir_fetch_seq and its bench.
package ir_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_e;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_BYTES  = 4;

endpackage

// File: rtl/ir_fetch_seq.sv
// Byte-serial instruction fetch: BYTES reads, one-hot irwrite, then pcen.
// Ports: clk, reset(n), fetch_req, pc, mem_addr/mem_rd/mem_ack, irwrite,
// pcen, pc_next, busy, done; flush when IR_FETCH_FLUSH_EN is defined.
module ir_fetch_seq
  import ir_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BYTES  = DEF_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
`ifdef IR_FETCH_FLUSH_EN
  input  logic              flush,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  output logic [BYTES-1:0]  irwrite,
  output logic              pcen,
  output logic [ADDR_W-1:0] pc_next,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES - 1);

  fetch_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              flush_w;

`ifdef IR_FETCH_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    base_d   = base_q;
    mem_addr = '0;
    mem_rd   = 1'b0;
    irwrite  = '0;
    pcen     = 1'b0;
    pc_next  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // flush outranks a request arriving the same cycle
        if (fetch_req && !flush_w) begin
          base_d  = pc;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        mem_rd   = 1'b1;
        busy     = 1'b1;
        mem_addr = base_q + ADDR_W'(idx_q);
        if (flush_w) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (mem_ack) begin
          irwrite[idx_q] = 1'b1;
          if (idx_q == LAST) state_d = DONE;
          else idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        busy    = 1'b1;
        pc_next = base_q + ADDR_W'(BYTES);
        state_d = IDLE;
        if (flush_w) begin
          idx_d = '0;
        end else begin
          pcen = 1'b1;
          done = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ir_fetch_seq.sv
// Directed bench for ir_fetch_seq (BYTES=4, ADDR_W=8).
// Flush steps compile in when IR_FETCH_FLUSH_EN is defined.
module tb_ir_fetch_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_req;
  logic [7:0] pc;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_ack;
  logic [3:0] irwrite;
  logic       pcen;
  logic [7:0] pc_next;
  logic       busy;
  logic       done;
`ifdef IR_FETCH_FLUSH_EN
  logic       flush;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ir_fetch_seq #(.ADDR_W(8), .BYTES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .fetch_req (fetch_req),
    .pc        (pc),
`ifdef IR_FETCH_FLUSH_EN
    .flush     (flush),
`endif
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_ack   (mem_ack),
    .irwrite   (irwrite),
    .pcen      (pcen),
    .pc_next   (pc_next),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [7:0] a,
                      input logic rd, input logic [3:0] irw,
                      input logic pe, input logic [7:0] pn,
                      input logic bz, input logic dn);
    #1;
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, ".mem_rd"},   32'(mem_rd),   32'(rd));
    chk({tag, ".irwrite"},  32'(irwrite),  32'(irw));
    chk({tag, ".pcen"},     32'(pcen),     32'(pe));
    chk({tag, ".pc_next"},  32'(pc_next),  32'(pn));
    chk({tag, ".busy"},     32'(busy),     32'(bz));
    chk({tag, ".done"},     32'(done),     32'(dn));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    fetch_req = 1'b1;
    mem_ack   = 1'b1;
    pc        = 8'h10;
`ifdef IR_FETCH_FLUSH_EN
    flush     = 1'b0;
`endif
    // 1: reset holds everything at zero despite active inputs
    outs("rst0", 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0);
    tick();
    outs("rst1", 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0);
    reset = 1'b1;
    // 2: zero-wait fetch of 0x10
    tick();
    fetch_req = 1'b0;
    outs("zw_b0", 8'h10, 1, 4'b0001, 0, 8'h00, 1, 0);
    tick();
    outs("zw_b1", 8'h11, 1, 4'b0010, 0, 8'h00, 1, 0);
    tick();
    outs("zw_b2", 8'h12, 1, 4'b0100, 0, 8'h00, 1, 0);
    tick();
    outs("zw_b3", 8'h13, 1, 4'b1000, 0, 8'h00, 1, 0);
    tick();
    outs("zw_done", 8'h00, 0, 4'b0000, 1, 8'h14, 1, 1);
    tick();
    outs("zw_idle", 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0);
    // 3: three wait states on byte 1 of 0x20
    pc = 8'h20;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    outs("ws_b0", 8'h20, 1, 4'b0001, 0, 8'h00, 1, 0);
    tick();
    mem_ack = 1'b0;
    outs("ws_w1", 8'h21, 1, 4'b0000, 0, 8'h00, 1, 0);
    tick();
    outs("ws_w2", 8'h21, 1, 4'b0000, 0, 8'h00, 1, 0);
    tick();
    outs("ws_w3", 8'h21, 1, 4'b0000, 0, 8'h00, 1, 0);
    tick();
    mem_ack = 1'b1;
    outs("ws_b1", 8'h21, 1, 4'b0010, 0, 8'h00, 1, 0);
    tick();
    outs("ws_b2", 8'h22, 1, 4'b0100, 0, 8'h00, 1, 0);
    tick();
    outs("ws_b3", 8'h23, 1, 4'b1000, 0, 8'h00, 1, 0);
    tick();
    outs("ws_done", 8'h00, 0, 4'b0000, 1, 8'h24, 1, 1);
    tick();
    outs("ws_idle", 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0);
    // 4: wrap at 0xFE; request for 0x40 held during the fetch
    pc = 8'hFE;
    fetch_req = 1'b1;
    tick();
    pc = 8'h40;
    outs("wr_b0", 8'hFE, 1, 4'b0001, 0, 8'h00, 1, 0);
    tick();
    outs("wr_b1", 8'hFF, 1, 4'b0010, 0, 8'h00, 1, 0);
    tick();
    outs("wr_b2", 8'h00, 1, 4'b0100, 0, 8'h00, 1, 0);
    tick();
    outs("wr_b3", 8'h01, 1, 4'b1000, 0, 8'h00, 1, 0);
    tick();
    outs("wr_done", 8'h00, 0, 4'b0000, 1, 8'h02, 1, 1);
    tick();
    outs("wr_idle", 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0);
    tick();
    fetch_req = 1'b0;
    outs("nx_b0", 8'h40, 1, 4'b0001, 0, 8'h00, 1, 0);
    tick();
    outs("nx_b1", 8'h41, 1, 4'b0010, 0, 8'h00, 1, 0);
    // 5: asynchronous reset in the middle of the fetch
    tick();
    reset = 1'b0;
    outs("mr_abort", 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0);
    tick();
    outs("mr_hold", 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0);
    reset = 1'b1;
    pc = 8'h50;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    outs("rs_b0", 8'h50, 1, 4'b0001, 0, 8'h00, 1, 0);
    tick();
    outs("rs_b1", 8'h51, 1, 4'b0010, 0, 8'h00, 1, 0);
    tick();
    outs("rs_b2", 8'h52, 1, 4'b0100, 0, 8'h00, 1, 0);
    tick();
    outs("rs_b3", 8'h53, 1, 4'b1000, 0, 8'h00, 1, 0);
    tick();
    outs("rs_done", 8'h00, 0, 4'b0000, 1, 8'h54, 1, 1);
    tick();
    outs("rs_idle", 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0);
`ifdef IR_FETCH_FLUSH_EN
    // 6: flush during byte 2, then flush blocking a request in IDLE
    pc = 8'h60;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    outs("fl_b0", 8'h60, 1, 4'b0001, 0, 8'h00, 1, 0);
    tick();
    outs("fl_b1", 8'h61, 1, 4'b0010, 0, 8'h00, 1, 0);
    tick();
    flush = 1'b1;
    outs("fl_b2", 8'h62, 1, 4'b0000, 0, 8'h00, 1, 0);
    tick();
    flush = 1'b0;
    outs("fl_idle", 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0);
    tick();
    outs("fl_idle2", 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0);
    pc = 8'h70;
    fetch_req = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch_req = 1'b0;
    outs("fl_block", 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
